// File: rtl/video_stream_gen.sv
// Raster timing generator (de/hsync/vsync/x/y) with a rectangular mask box loaded through a shadow register.
// Build macro VIDEO_STREAM_GEN_BOUNCE_EN: box origin steps one pixel/line per frame, bouncing off the image edges.
module video_stream_gen #(
   parameter int IMG_W   = 720,
   parameter int IMG_H   = 576,
   parameter int H_BLANK = 144,
   parameter int H_SYNC  = 64,
   parameter int V_BLANK = 49
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic       enable,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [9:0] cfg_x0,
   input  logic [9:0] cfg_y0,
   input  logic [9:0] cfg_w,
   input  logic [9:0] cfg_h,
   output logic       de,
   output logic       hsync,
   output logic       vsync,
   output logic       mask,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       frame_done
);

   // state  | meaning
   // IDLE   | stopped, waiting for enable
   // ACTIVE | IMG_H lines of pixels + horizontal blank
   // VBLANK | V_BLANK blank lines, enable decides restart or stop
   typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;

   localparam logic [9:0] PIX_LAST = 10'(IMG_W + H_BLANK - 1);
   localparam logic [9:0] W_L      = 10'(IMG_W);
   localparam logic [9:0] HS_END   = 10'(IMG_W + H_SYNC);
   localparam logic [9:0] ACT_LAST = 10'(IMG_H - 1);
   localparam logic [9:0] VB_LAST  = 10'(V_BLANK - 1);

   state_t     state_q, state_d;
   logic [9:0] pix_q, pix_d, line_q, line_d;
   logic [9:0] box_x0_q, box_x0_d, box_y0_q, box_y0_d, box_w_q, box_w_d, box_h_q, box_h_d;
   logic [9:0] sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d, sh_w_q, sh_w_d, sh_h_q, sh_h_d;
   logic       sh_full_q, sh_full_d;
   logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, mask_q, mask_d, frame_done_q, frame_done_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       enter_active, cfg_xfer;
   logic [10:0] x_end, y_end;

`ifdef VIDEO_STREAM_GEN_BOUNCE_EN
   logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;

   // Returns {new_dir_up, new_pos}; direction flips once the position touches 0 or lim.
   function automatic logic [10:0] bounce_step(input logic [9:0] pos, input logic up,
                                               input logic [9:0] lim);
      logic [9:0] np;
      logic       nu;
      if (up) begin
         if (pos >= lim) begin
            np = pos - 10'd1;
            nu = 1'b0;
         end else begin
            np = pos + 10'd1;
            nu = (np < lim);
         end
      end else begin
         if (pos == 10'd0) begin
            np = 10'd1;
            nu = 1'b1;
         end else begin
            np = pos - 10'd1;
            nu = (np == 10'd0);
         end
      end
      return {nu, np};
   endfunction
`endif

   always_comb begin
      state_d      = state_q;
      pix_d        = pix_q;
      line_d       = line_q;
      enter_active = 1'b0;
      if (ce) begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_d      = ACTIVE;
                  pix_d        = 10'd0;
                  line_d       = 10'd0;
                  enter_active = 1'b1;
               end
            end
            ACTIVE: begin
               if (pix_q == PIX_LAST) begin
                  pix_d = 10'd0;
                  if (line_q == ACT_LAST) begin
                     state_d = VBLANK;
                     line_d  = 10'd0;
                  end else begin
                     line_d = line_q + 10'd1;
                  end
               end else begin
                  pix_d = pix_q + 10'd1;
               end
            end
            VBLANK: begin
               if (pix_q == PIX_LAST) begin
                  pix_d = 10'd0;
                  if (line_q == VB_LAST) begin
                     line_d = 10'd0;
                     if (enable) begin
                        state_d      = ACTIVE;
                        enter_active = 1'b1;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     line_d = line_q + 10'd1;
                  end
               end else begin
                  pix_d = pix_q + 10'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Shadow copy happens only on ACTIVE entry, so a same-edge transfer lands in the shadow for the next frame.
   always_comb begin
      cfg_xfer  = cfg_valid && !sh_full_q;
      sh_x0_d   = sh_x0_q;
      sh_y0_d   = sh_y0_q;
      sh_w_d    = sh_w_q;
      sh_h_d    = sh_h_q;
      box_x0_d  = box_x0_q;
      box_y0_d  = box_y0_q;
      box_w_d   = box_w_q;
      box_h_d   = box_h_q;
      sh_full_d = sh_full_q && !enter_active;
`ifdef VIDEO_STREAM_GEN_BOUNCE_EN
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
`endif
      if (enter_active) begin
         if (sh_full_q) begin
            box_x0_d = sh_x0_q;
            box_y0_d = sh_y0_q;
            box_w_d  = sh_w_q;
            box_h_d  = sh_h_q;
         end
`ifdef VIDEO_STREAM_GEN_BOUNCE_EN
         else begin
            {dir_x_d, box_x0_d} = bounce_step(box_x0_q, dir_x_q, 10'(IMG_W - 1));
            {dir_y_d, box_y0_d} = bounce_step(box_y0_q, dir_y_q, 10'(IMG_H - 1));
         end
`endif
      end
      if (cfg_xfer) begin
         sh_x0_d   = cfg_x0;
         sh_y0_d   = cfg_y0;
         sh_w_d    = cfg_w;
         sh_h_d    = cfg_h;
         sh_full_d = 1'b1;
      end
   end

   // Outputs are derived from the next counter values so every output moves on the same edge.
   always_comb begin
      de_d         = de_q;
      hsync_d      = hsync_q;
      vsync_d      = vsync_q;
      mask_d       = mask_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_done_d = frame_done_q;
      x_end        = {1'b0, box_x0_d} + {1'b0, box_w_d};
      y_end        = {1'b0, box_y0_d} + {1'b0, box_h_d};
      if (ce) begin
         vsync_d      = (state_d == ACTIVE);
         de_d         = (state_d == ACTIVE) && (pix_d < W_L);
         hsync_d      = !((state_d != IDLE) && (pix_d >= W_L) && (pix_d < HS_END));
         x_d          = de_d ? pix_d : 10'd0;
         y_d          = de_d ? line_d : 10'd0;
         mask_d       = de_d
                        && ({1'b0, pix_d} >= {1'b0, box_x0_d}) && ({1'b0, pix_d} < x_end)
                        && ({1'b0, line_d} >= {1'b0, box_y0_d}) && ({1'b0, line_d} < y_end);
         frame_done_d = vsync_q && !vsync_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pix_q        <= 10'd0;
         line_q       <= 10'd0;
         box_x0_q     <= 10'd0;
         box_y0_q     <= 10'd0;
         box_w_q      <= 10'd0;
         box_h_q      <= 10'd0;
         sh_x0_q      <= 10'd0;
         sh_y0_q      <= 10'd0;
         sh_w_q       <= 10'd0;
         sh_h_q       <= 10'd0;
         sh_full_q    <= 1'b0;
         de_q         <= 1'b0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b0;
         mask_q       <= 1'b0;
         x_q          <= 10'd0;
         y_q          <= 10'd0;
         frame_done_q <= 1'b0;
`ifdef VIDEO_STREAM_GEN_BOUNCE_EN
         dir_x_q      <= 1'b1;
         dir_y_q      <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         pix_q        <= pix_d;
         line_q       <= line_d;
         box_x0_q     <= box_x0_d;
         box_y0_q     <= box_y0_d;
         box_w_q      <= box_w_d;
         box_h_q      <= box_h_d;
         sh_x0_q      <= sh_x0_d;
         sh_y0_q      <= sh_y0_d;
         sh_w_q       <= sh_w_d;
         sh_h_q       <= sh_h_d;
         sh_full_q    <= sh_full_d;
         de_q         <= de_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         mask_q       <= mask_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
`ifdef VIDEO_STREAM_GEN_BOUNCE_EN
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
`endif
      end
   end

   assign cfg_ready  = !sh_full_q;
   assign de         = de_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign mask       = mask_q;
   assign x          = x_q;
   assign y          = y_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: fixed vectors, directed corner sequences and a random run
// compared against a frame-phase reference model.
module tb_video_stream_gen;
   localparam int W = 8, H = 4, HB = 4, HS = 2, VB = 2;
   localparam int LINE = W + HB, ACT = LINE * H, FRAME = LINE * (H + VB);

   logic clk = 1'b0;
   logic rst, ce, enable, cfg_valid, cfg_ready;
   logic [9:0] cfg_x0, cfg_y0, cfg_w, cfg_h, x, y;
   logic de, hsync, vsync, mask, frame_done;
   logic [25:0] dut_o;

   always #5 clk = ~clk;

   video_stream_gen #(.IMG_W(W), .IMG_H(H), .H_BLANK(HB), .H_SYNC(HS), .V_BLANK(VB)) dut (
      .clk(clk), .rst(rst), .ce(ce), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
      .x(x), .y(y), .frame_done(frame_done)
   );

   assign dut_o = {de, hsync, vsync, mask, frame_done, cfg_ready, x, y};

   int n_checks = 0, n_fail = 0;
   int acc_mask, acc_minx, acc_fd;

   // Reference model: a running flag and the ce-cycle index within the current frame.
   bit m_run, m_sh_full;
   int m_n;
   int m_sh[4];
   int m_box[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [25:0] pk(input bit d, h, v, m, fd, rdy, input int xx, yy);
      return {d, h, v, m, fd, rdy, 10'(xx), 10'(yy)};
   endfunction

   task automatic model_update();
      bit start, xfer;
      start = 0;
      if (rst) begin
         m_run = 0; m_n = 0; m_sh_full = 0;
         m_box = '{0, 0, 0, 0};
      end else begin
         xfer = cfg_valid && !m_sh_full;
         if (ce) begin
            if (!m_run) begin
               if (enable) begin m_run = 1; m_n = 0; start = 1; end
            end else begin
               m_n++;
               if (m_n == FRAME) begin
                  m_n = 0;
                  if (enable) start = 1;
                  else m_run = 0;
               end
            end
         end
         if (start && m_sh_full) begin m_box = m_sh; m_sh_full = 0; end
         if (xfer) begin
            m_sh = '{int'(cfg_x0), int'(cfg_y0), int'(cfg_w), int'(cfg_h)};
            m_sh_full = 1;
         end
      end
   endtask

   function automatic logic [25:0] m_out();
      int col, ln, xx, yy;
      bit d, v, h, mk, fd;
      d = 0; v = 0; h = 1; mk = 0; fd = 0; xx = 0; yy = 0;
      if (m_run) begin
         col = m_n % LINE;
         ln  = m_n / LINE;
         v   = (m_n < ACT);
         h   = !(col >= W && col < W + HS);
         d   = v && col < W;
         if (d) begin xx = col; yy = ln; end
         mk  = d && xx >= m_box[0] && xx < m_box[0] + m_box[2]
                 && yy >= m_box[1] && yy < m_box[1] + m_box[3];
         fd  = (m_n == ACT);
      end
      return pk(d, h, v, mk, fd, !m_sh_full, xx, yy);
   endfunction

   task automatic step(input bit use_model, input string name);
      @(posedge clk);
      model_update();
      #1;
      if (use_model) chk(name, dut_o, m_out());
      acc_mask += int'(mask);
      acc_fd   += int'(frame_done);
      if (mask && int'(x) < acc_minx) acc_minx = int'(x);
   endtask

   task automatic clr_acc();
      acc_mask = 0; acc_fd = 0; acc_minx = 1000;
   endtask

   task automatic run_n(input int n, input string name);
      for (int i = 0; i < n; i++) step(1, name);
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; ce = 1; cfg_valid = 0;
      step(1, "reset");
      rst = 0;
   endtask

   task automatic load(input int bx, by, bw, bh);
      cfg_valid = 1; cfg_x0 = 10'(bx); cfg_y0 = 10'(by); cfg_w = 10'(bw); cfg_h = 10'(bh);
      step(1, "cfg_load");
      cfg_valid = 0;
   endtask

   typedef struct {
      logic        r, en, c;
      logic [25:0] exp;
   } vec_t;

   vec_t tbl[9];
   logic [25:0] idle_o;
   int t_rise, t_fd, n_de, n_hs_low;

   initial begin
      rst = 1; ce = 1; enable = 0; cfg_valid = 0;
      cfg_x0 = 0; cfg_y0 = 0; cfg_w = 0; cfg_h = 0;
      clr_acc();
      idle_o = pk(0, 1, 0, 0, 0, 1, 0, 0);
      tbl[0] = '{1'b1, 1'b0, 1'b1, idle_o};
      tbl[1] = '{1'b0, 1'b0, 1'b1, idle_o};
      tbl[2] = '{1'b0, 1'b1, 1'b0, idle_o};
      tbl[3] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 0, 0, 1, 0, 0)};
      tbl[4] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 0, 0, 1, 1, 0)};
      tbl[5] = '{1'b0, 1'b1, 1'b0, pk(1, 1, 1, 0, 0, 1, 1, 0)};
      tbl[6] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 1, 0, 0, 1, 2, 0)};
      tbl[7] = '{1'b1, 1'b1, 1'b0, idle_o};
      tbl[8] = '{1'b0, 1'b0, 1'b1, idle_o};
      for (int i = 0; i < 9; i++) begin
         rst = tbl[i].r; enable = tbl[i].en; ce = tbl[i].c;
         step(0, "");
         chk($sformatf("vec%0d", i), dut_o, tbl[i].exp);
      end

      // Basic frame timing
      do_reset();
      enable = 1;
      t_rise = -1; t_fd = -1; n_de = 0; n_hs_low = 0;
      for (int i = 1; i <= 200 && t_fd < 0; i++) begin
         step(1, "frame_run");
         if (vsync && t_rise < 0) t_rise = i;
         if (vsync) begin
            n_de += int'(de);
            n_hs_low += int'(!hsync);
         end
         if (frame_done) t_fd = i;
      end
      chk("fd_latency", 32'(t_fd - t_rise), 32'd48);
      chk("de_per_frame", 32'(n_de), 32'd32);
      chk("hsync_low_cnt", 32'(n_hs_low), 32'd8);

      // Box loaded in IDLE, then changed mid-frame
      do_reset();
      load(2, 1, 3, 2);
      chk("ready_after_load", 32'(cfg_ready), 32'd0);
      enable = 1;
      clr_acc();
      run_n(10, "box_frame1");
      load(5, 1, 3, 2);
      run_n(FRAME - 11, "box_frame1");
      chk("box_mask_cnt", 32'(acc_mask), 32'd6);
      chk("box_minx", 32'(acc_minx), 32'd2);
      chk("ready_mid_frame", 32'(cfg_ready), 32'd0);
      clr_acc();
      run_n(FRAME, "box_frame2");
      chk("box2_minx", 32'(acc_minx), 32'd5);
      chk("box2_mask_cnt", 32'(acc_mask), 32'd6);

      // Clipping at the right edge; w=0 handed over on the entry edge
      do_reset();
      load(6, 0, 5, 4);
      enable = 1;
      clr_acc();
      run_n(FRAME, "clip_frame");
      chk("clip_mask_cnt", 32'(acc_mask), 32'd8);
      chk("clip_minx", 32'(acc_minx), 32'd6);
      clr_acc();
      load(0, 0, 0, 4);
      run_n(FRAME - 1, "entry_edge_frame");
      chk("entry_edge_mask_cnt", 32'(acc_mask), 32'd8);
      clr_acc();
      run_n(FRAME, "w0_frame");
      chk("w0_mask_cnt", 32'(acc_mask), 32'd0);

      // ce toggling: every output value held two cycles
      do_reset();
      load(2, 1, 3, 2);
      enable = 1;
      clr_acc();
      for (int i = 0; i < 2 * FRAME; i++) begin
         ce = (i % 2 == 0);
         step(1, "ce_toggle");
      end
      ce = 1;
      chk("ce_mask_cnt", 32'(acc_mask), 32'd12);
      chk("ce_fd_cnt", 32'(acc_fd), 32'd2);

      // Reset at line 2 pixel 3
      do_reset();
      enable = 1;
      run_n(1 + 2 * LINE + 3, "pre_abort");
      chk("abort_pos", {22'd0, x}, 32'd3);
      chk("abort_line", {22'd0, y}, 32'd2);
      rst = 1;
      step(1, "abort");
      chk("abort_outputs", dut_o, idle_o);
      rst = 0; enable = 0;
      clr_acc();
      run_n(80, "post_abort");
      chk("abort_no_fd", 32'(acc_fd), 32'd0);

      // Random stimulus
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         ce = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 99) == 0) enable = !enable;
         cfg_valid = ($urandom_range(0, 19) == 0);
         cfg_x0 = 10'($urandom_range(0, 12));
         cfg_y0 = 10'($urandom_range(0, 6));
         cfg_w  = 10'($urandom_range(0, 10));
         cfg_h  = 10'($urandom_range(0, 6));
         step(1, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 Parameter IMG_W, default 720, active pixels per line (10-bit).
REQ-002 Parameter IMG_H, default 576, active lines per frame (10-bit).
REQ-003 Parameter H_BLANK, default 144, blank cycles per line; H_SYNC, default 64, hsync-low cycles (H_SYNC < H_BLANK).
REQ-004 Parameter V_BLANK, default 49, blank lines per frame.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ce  in  1  clock enable; counters/state advance only when ce=1, outputs hold when ce=0.
REQ-008 enable  in  1  run request; sampled only at frame boundary.
REQ-009 cfg_valid  in  1 / cfg_ready  out  1  box-load handshake; transfer when both high on a clock edge.
REQ-010 cfg_x0, cfg_y0, cfg_w, cfg_h  in  10 each  box origin and size.
REQ-011 de, hsync, vsync, mask  out  1 each  pixel stream to skin-mask consumers.
REQ-012 x, y  out  10 each  coordinate of the pixel presented this cycle.
REQ-013 frame_done  out  1  one-cycle pulse on vsync 1->0.

Function
REQ-014 States IDLE, ACTIVE, VBLANK; IDLE->ACTIVE when enable=1; ACTIVE->VBLANK after last cycle of line IMG_H-1; VBLANK->ACTIVE after V_BLANK lines if enable=1, else ->IDLE.
REQ-015 Line = IMG_W+H_BLANK ce-cycles; pixel counter wraps to 0 at IMG_W+H_BLANK-1, line counter increments on wrap.
REQ-016 vsync=1 in ACTIVE, 0 in IDLE/VBLANK.
REQ-017 de=1 only in ACTIVE with pixel counter < IMG_W.
REQ-018 hsync=0 for pixel counter in [IMG_W, IMG_W+H_SYNC-1], 1 otherwise, in ACTIVE and VBLANK; 1 in IDLE.
REQ-019 x = pixel counter, y = line counter while de=1; x, y = 0 when de=0.
REQ-020 All outputs registered; de, vsync, hsync, mask, x, y change on the same edge (zero relative skew).
REQ-021 mask = de AND x0<=x<x0+w AND y0<=y<y0+h, compared at 11 bits; w=0 or h=0 gives mask=0; box past image edge is clipped, no wrap.
REQ-022 cfg_ready=1 when shadow register empty; a transfer fills the shadow and drops cfg_ready next cycle.
REQ-023 Shadow copied to active box on the cycle entering ACTIVE; cfg_ready rises next cycle; box never changes mid-frame.
REQ-024 Transfer on the same edge as the ACTIVE entry is applied to the next frame, not the current one.
REQ-025 frame_done=1 for exactly the one cycle where vsync goes 1->0.
REQ-026 enable dropped mid-frame: current frame and its VBLANK complete, then IDLE.

Reset
REQ-027 rst=1 on an edge (regardless of ce): state IDLE, counters 0, de=0, vsync=0, hsync=1, mask=0, x=y=0, frame_done=0, cfg_ready=1, shadow empty, active box all zero.
REQ-028 Reset mid-frame aborts the frame immediately without a frame_done pulse.

Configuration
REQ-029 Macro VIDEO_STREAM_GEN_BOUNCE_EN defined: at each ACTIVE entry without a pending shadow, box x0 and y0 each move 1 in their current direction, direction reverses when box edge reaches 0 or IMG_W-1/IMG_H-1; directions reset to +1.
REQ-030 Macro undefined: box static between shadow loads; no bounce logic present.

Verification (IMG_W=8, IMG_H=4, H_BLANK=4, H_SYNC=2, V_BLANK=2)
REQ-031 rst, then enable=1, ce=1 -> vsync rises, 8 de cycles per 12-cycle line, 4 lines, frame_done after 48 cycles, hsync low at counts 8-9.
REQ-032 Load x0=2,y0=1,w=3,h=2 in IDLE -> next frame mask=1 exactly at (2..4,1..2), 6 pixels total.
REQ-033 cfg_valid mid-frame with x0=5 -> current frame unchanged, next frame mask starts x=5; cfg_ready low until that entry.
REQ-034 x0=6,w=5 -> mask only at x=6,7; w=0 -> no mask anywhere.
REQ-035 ce toggled 1/0 every cycle -> identical output sequence, each value held 2 cycles.
REQ-036 rst at line 2 pixel 3 -> next cycle all outputs at reset values, no frame_done; BOUNCE_EN build: box x0 1->2->3 across frames.
